dg0045_ram_scan_arbiter: RTL and testbench
==========================================

Name: dg0045_ram_scan_arbiter

Overview:
Shares the single-port 64x4 data RAM between the DG0045 core and a multiplexed digit-display refresh scanner. The core has priority. The scanner walks a block of RAM holding digit codes and drives one-hot digit selects, with a blanking gap between digits. The block sits between the core's RAM address/data bus and the RAM macro. RAM read is combinational; RAM write commits on the clock edge.

Parameters:
N_DIGITS, 4, number of scanned digits (2..8)
SCAN_BASE, 6'h30, RAM address of digit 0; digit i is at SCAN_BASE+i, wrapping mod 64
REFRESH_DIV, 16, cycles each digit stays in SHOW before the next fetch is requested (>=2)
BLANK_CYC, 2, cycles with all digit selects off between digits (>=1)
STARVE_MAX, 8, consecutive denied scanner cycles before a forced slot (only with the macro)

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  core requests the RAM this cycle
cpu_we  in  1  write when granted
cpu_addr  in  6  {BU,BL}
cpu_din  in  4  write data
cpu_gnt  out  1  combinational grant for the core
cpu_dout  out  4  ram_dout, valid in the grant cycle
ram_addr  out  6  to RAM
ram_din  out  4  to RAM
ram_we  out  1  RAM write enable; asserted only for a granted core write
ram_dout  in  4  RAM combinational read data
dig_sel  out  N_DIGITS  one-hot active-high digit enable
dig_data  out  4  code of the displayed digit
scan_busy  out  1  scanner in REQ state

Behaviour:
- Reset (async, rst_n=0):
  - state=SHOW; idx=0; div=0; blank_cnt=0; wait_cnt=0.
  - dig_sel=0; dig_data=0; cpu_gnt=0; ram_we=0.
  - Mid-operation reset drops any pending scan fetch. No RAM write can occur while rst_n=0.
- Arbitration (combinational):
  - scan_req = (state==REQ); scan_gnt = scan_req & (~cpu_req | force).
  - cpu_gnt = cpu_req & ~scan_gnt.
  - force=0 without the macro.
- RAM mux:
  - scan_gnt: ram_addr = SCAN_BASE+idx (6-bit wrap), ram_we=0.
  - Otherwise: ram_addr=cpu_addr, ram_din=cpu_din, ram_we = cpu_gnt & cpu_we.
  - A core held off by force must keep cpu_req and its operands until cpu_gnt=1. Nothing is queued.
- Scanner FSM:
  - SHOW: div increments each cycle. At div==REFRESH_DIV-1, go to REQ and set div=0. dig_sel and dig_data hold.
  - REQ: each cycle without scan_gnt, stay in REQ; the old digit keeps showing.
  - REQ with scan_gnt, on that edge: dig_data<=ram_dout, dig_sel<=0, latched index<=idx, idx<=idx+1 (N_DIGITS-1 wraps to 0), go to BLANK with blank_cnt=0.
  - BLANK: dig_sel=0. After BLANK_CYC cycles, dig_sel<=onehot(latched index) and go to SHOW.
- Timing:
  - Fetch-to-visible latency is BLANK_CYC+1 edges after the grant edge.
  - Uncontended digit period is REFRESH_DIV+1+BLANK_CYC cycles.
- First digit after reset:
  - dig_sel stays 0 until the first fetch completes.
  - dig_sel first becomes 4'b0001 at edge REFRESH_DIV+1+BLANK_CYC after reset release.
- Core writing the scanned address:
  - A write granted in cycle t is visible to any scanner fetch at cycle t+1 or later.
- Simultaneous core request and scanner request: the core wins unless force=1.

Optional Feature:
DG0045_SCAN_STARVE_EN
- Defined:
  - wait_cnt counts cycles in REQ with scan_gnt=0. It clears on scan_gnt and on leaving REQ.
  - force = (wait_cnt==STARVE_MAX). The scanner then takes exactly that one cycle and cpu_gnt=0.
  - Worst-case core stall: 1 cycle per digit period.
- Undefined:
  - wait_cnt is absent and force=0.
  - The core always wins. The scanner may remain in REQ indefinitely while cpu_req=1, showing a stale digit with dig_sel still on.

Test Plan:
- Reset, RAM[0x30..0x33]=5,6,7,8, cpu_req=0 → dig_sel=0001, dig_data=5 at edge 19. Then 0010/6, 0100/7, 1000/8, wrapping to 0001/5. dig_sel=0 for exactly 2 cycles between digits.
- Core writes 0x31=0xA at edge 3 → second displayed digit shows 0xA. ram_we pulses only in the granted cycle.
- cpu_req held high through a REQ period, macro undefined → cpu_gnt stays 1, scan_busy stays 1, dig_sel/dig_data frozen. Drop cpu_req → fetch completes on the next edge.
- Same stimulus with DG0045_SCAN_STARVE_EN → after 8 denied cycles, cpu_gnt=0 for exactly one cycle, ram_addr=SCAN_BASE+idx, then cpu_gnt=1 again.
- SCAN_BASE=6'h3E, N_DIGITS=4 → fetch addresses 0x3E, 0x3F, 0x00, 0x01.
- rst_n pulsed low while in REQ and again in BLANK → all outputs return to reset values immediately. Scan restarts at digit 0 with no RAM write.

Source files
------------

// File: rtl/dg0045_ram_scan_arbiter_if.sv
// -----------------------------------------------------------------------------
// dg0045_ram_scan_arbiter_if
// Bus bundle between the DG0045 core, the scan arbiter and the 64x4 data RAM.
//
// Signals:
//   cpu_req  core requests the RAM this cycle
//   cpu_we   core write when granted
//   cpu_addr core address {BU,BL}
//   cpu_din  core write data
//   cpu_gnt  combinational grant back to the core
//   cpu_dout RAM read data returned to the core (valid in the grant cycle)
//   ram_addr address to the RAM macro
//   ram_din  write data to the RAM macro
//   ram_we   write enable to the RAM macro
//   ram_dout combinational read data from the RAM macro
//
// Modports:
//   master  core/RAM side: drives the request operands and the RAM read data
//   slave   arbiter side: drives the grant and the RAM address/data/enable
// -----------------------------------------------------------------------------
interface dg0045_ram_scan_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [5:0] cpu_addr;
  logic [3:0] cpu_din;
  logic       cpu_gnt;
  logic [3:0] cpu_dout;
  logic [5:0] ram_addr;
  logic [3:0] ram_din;
  logic       ram_we;
  logic [3:0] ram_dout;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  cpu_gnt, cpu_dout, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output cpu_gnt, cpu_dout, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/dg0045_ram_scan_arbiter.sv
// -----------------------------------------------------------------------------
// dg0045_ram_scan_arbiter
// Shares the single-port 64x4 data RAM between the DG0045 core and a
// multiplexed digit-display refresh scanner. The core has priority. The
// scanner walks N_DIGITS consecutive RAM words starting at SCAN_BASE and
// drives one-hot digit selects with a BLANK_CYC blanking gap between digits.
//
// Optional feature macro: DG0045_SCAN_STARVE_EN
//   defined   : after STARVE_MAX consecutive denied scanner cycles the scanner
//               takes one forced slot (core sees cpu_gnt=0 for that cycle).
//   undefined : the core always wins; the scanner may wait indefinitely.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   bus        dg0045_ram_scan_arbiter_if.slave (core request/grant + RAM bus)
//   dig_sel    one-hot active-high digit enable (N_DIGITS bits)
//   dig_data   code of the displayed digit
//   scan_busy  scanner is waiting for its RAM slot (REQ state)
// -----------------------------------------------------------------------------
module dg0045_ram_scan_arbiter #(
  parameter int unsigned N_DIGITS    = 4,
  parameter logic [5:0]  SCAN_BASE   = 6'h30,
  parameter int unsigned REFRESH_DIV = 16,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dg0045_ram_scan_arbiter_if.slave  bus,
  output logic [N_DIGITS-1:0]       dig_sel,
  output logic [3:0]                dig_data,
  output logic                      scan_busy
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  scan_state_t          state_r,     state_n_s;
  logic [IDX_W-1:0]     idx_r,       idx_n_s;
  logic [IDX_W-1:0]     lat_idx_r,   lat_idx_n_s;
  logic [DIV_W-1:0]     div_r,       div_n_s;
  logic [BLK_W-1:0]     blank_cnt_r, blank_cnt_n_s;
  logic [N_DIGITS-1:0]  dig_sel_r,   dig_sel_n_s;
  logic [3:0]           dig_data_r,  dig_data_n_s;

  logic                 scan_req_s;
  logic                 scan_gnt_s;
  logic                 force_s;
  logic [IDX_W-1:0]     idx_inc_s;
  logic [5:0]           scan_addr_s;
  logic [N_DIGITS-1:0]  onehot_s;

  assign scan_req_s  = (state_r == ST_REQ);
  assign scan_gnt_s  = scan_req_s & (~bus.cpu_req | force_s);
  assign idx_inc_s   = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
  // 6-bit addition wraps naturally mod 64, so a block straddling 0x3F is fine.
  assign scan_addr_s = SCAN_BASE + 6'(idx_r);
  assign onehot_s    = {{(N_DIGITS-1){1'b0}}, 1'b1} << lat_idx_r;

`ifdef DG0045_SCAN_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_MAX + 1);

  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_n_s;

  // The forced slot fires on the cycle after STARVE_MAX denials, then the
  // counter clears because the scanner is granted that cycle.
  assign force_s = scan_req_s & (wait_cnt_r == WAIT_W'(STARVE_MAX));

  // Starvation counter next value: counts only denied REQ cycles.
  always_comb begin
    wait_cnt_n_s = {WAIT_W{1'b0}};
    if (scan_req_s && !scan_gnt_s) begin
      wait_cnt_n_s = wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_n_s = {WAIT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_n_s;
    end
  end
`else
  logic unused_starve_s;

  assign force_s         = 1'b0;
  assign unused_starve_s = ^(32'(STARVE_MAX));
`endif

  // RAM mux and core grant. The grant is held low during reset so that no
  // RAM write can be issued while rst_n is asserted.
  always_comb begin
    bus.cpu_gnt  = 1'b0;
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_din;
    bus.ram_we   = 1'b0;
    bus.cpu_dout = bus.ram_dout;
    if (scan_gnt_s) begin
      bus.cpu_gnt  = 1'b0;
      bus.ram_addr = scan_addr_s;
      bus.ram_din  = 4'h0;
      bus.ram_we   = 1'b0;
    end else begin
      bus.cpu_gnt  = bus.cpu_req & rst_n;
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_din;
      bus.ram_we   = bus.cpu_req & rst_n & bus.cpu_we;
    end
  end

  // Scanner next-state and display update.
  always_comb begin
    state_n_s     = state_r;
    idx_n_s       = idx_r;
    lat_idx_n_s   = lat_idx_r;
    div_n_s       = div_r;
    blank_cnt_n_s = blank_cnt_r;
    dig_sel_n_s   = dig_sel_r;
    dig_data_n_s  = dig_data_r;
    case (state_r)
      ST_SHOW: begin
        if (div_r == DIV_LAST) begin
          state_n_s = ST_REQ;
          div_n_s   = {DIV_W{1'b0}};
        end else begin
          div_n_s   = div_r + DIV_W'(1);
        end
      end
      ST_REQ: begin
        // Without a grant the old digit simply keeps showing.
        if (scan_gnt_s) begin
          dig_data_n_s  = bus.ram_dout;
          dig_sel_n_s   = {N_DIGITS{1'b0}};
          lat_idx_n_s   = idx_r;
          idx_n_s       = idx_inc_s;
          blank_cnt_n_s = {BLK_W{1'b0}};
          state_n_s     = ST_BLANK;
        end else begin
          state_n_s     = ST_REQ;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_r == BLK_LAST) begin
          dig_sel_n_s   = onehot_s;
          blank_cnt_n_s = {BLK_W{1'b0}};
          state_n_s     = ST_SHOW;
        end else begin
          blank_cnt_n_s = blank_cnt_r + BLK_W'(1);
        end
      end
      default: begin
        state_n_s   = ST_SHOW;
        dig_sel_n_s = {N_DIGITS{1'b0}};
      end
    endcase
  end

  // Scanner state and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SHOW;
      idx_r       <= {IDX_W{1'b0}};
      lat_idx_r   <= {IDX_W{1'b0}};
      div_r       <= {DIV_W{1'b0}};
      blank_cnt_r <= {BLK_W{1'b0}};
      dig_sel_r   <= {N_DIGITS{1'b0}};
      dig_data_r  <= 4'h0;
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      lat_idx_r   <= lat_idx_n_s;
      div_r       <= div_n_s;
      blank_cnt_r <= blank_cnt_n_s;
      dig_sel_r   <= dig_sel_n_s;
      dig_data_r  <= dig_data_n_s;
    end
  end

  assign dig_sel   = dig_sel_r;
  assign dig_data  = dig_data_r;
  assign scan_busy = scan_req_s;

endmodule

// File: tb/tb_dg0045_ram_scan_arbiter.sv
`timescale 1ns/1ps
module tb_dg0045_ram_scan_arbiter;
  localparam int N    = 4;
  localparam int RDIV = 16;
  localparam int BLK  = 2;
  localparam int SMAX = 8;
  localparam logic [5:0] BASE   = 6'h30;
  localparam logic [5:0] BASE_W = 6'h3E;
`ifdef DG0045_SCAN_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] dig_sel, dig_sel_w;
  logic [3:0]   dig_data, dig_data_w;
  logic         scan_busy, scan_busy_w;

  dg0045_ram_scan_arbiter_if bus ();
  dg0045_ram_scan_arbiter_if ifw ();

  dg0045_ram_scan_arbiter #(.N_DIGITS(N), .SCAN_BASE(BASE), .REFRESH_DIV(RDIV),
                            .BLANK_CYC(BLK), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .dig_sel(dig_sel), .dig_data(dig_data), .scan_busy(scan_busy));

  // Second instance with a scan block that wraps past address 0x3F.
  dg0045_ram_scan_arbiter #(.N_DIGITS(N), .SCAN_BASE(BASE_W), .REFRESH_DIV(RDIV),
                            .BLANK_CYC(BLK), .STARVE_MAX(SMAX)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifw.slave),
    .dig_sel(dig_sel_w), .dig_data(dig_data_w), .scan_busy(scan_busy_w));

  always #5 clk = ~clk;

  // RAM stand-in with a backdoor load port.
  logic [3:0] mem [64];
  logic       bd_we = 1'b0;
  logic [5:0] bd_addr = 6'h0;
  logic [3:0] bd_din = 4'h0;
  assign bus.ram_dout = mem[bus.ram_addr];
  assign ifw.ram_dout = mem[ifw.ram_addr];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_din;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
  end

  int total = 0;
  int bad = 0;

  // Reference model: absolute-cycle schedule of requests, grants and reveals.
  logic [3:0]   ref_mem [64];
  int           cyc, req_start, show_at, m_idx, lat_idx, w_k;
  logic [3:0]   m_data;
  logic [N-1:0] m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; req_start = RDIV; show_at = -1;
    m_idx = 0; lat_idx = 0; m_data = 4'h0; m_sel = {N{1'b0}}; w_k = 0;
  endtask

  // One clock cycle: inputs already applied at the negedge; check, then advance.
  task automatic step();
    bit req, grant, force_m, exp_gnt, exp_we;
    logic [5:0] scan_addr, exp_addr, exp_w;
    #1;
    req       = (cyc >= req_start);
    force_m   = STARVE && req && ((cyc - req_start) == SMAX);
    grant     = req && (!bus.cpu_req || force_m);
    exp_gnt   = bus.cpu_req && !grant;
    exp_we    = exp_gnt && bus.cpu_we;
    scan_addr = BASE + 6'(m_idx);
    exp_addr  = grant ? scan_addr : bus.cpu_addr;
    chk("scan_busy", 32'(scan_busy), 32'(req));
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(exp_gnt));
    chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
    if (exp_gnt) chk("cpu_dout", 32'(bus.cpu_dout), 32'(ref_mem[bus.cpu_addr]));
    if (exp_we) chk("ram_din", 32'(bus.ram_din), 32'(bus.cpu_din));
    chk("dig_sel", 32'(dig_sel), 32'(m_sel));
    chk("dig_data", 32'(dig_data), 32'(m_data));
    if (scan_busy_w) begin
      exp_w = BASE_W + 6'(w_k % N);
      chk("wrap_addr", 32'(ifw.ram_addr), 32'(exp_w));
      w_k++;
    end
    if (exp_we) ref_mem[bus.cpu_addr] = bus.cpu_din;
    if (grant) begin
      m_data = ref_mem[scan_addr];
      m_sel = {N{1'b0}};
      lat_idx = m_idx;
      m_idx = (m_idx + 1) % N;
      show_at = cyc + BLK + 1;
      req_start = show_at + RDIV;
    end
    @(posedge clk);
    cyc++;
    if (cyc == show_at) begin
      m_sel = {N{1'b0}};
      m_sel[lat_idx] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_sel"}, 32'(dig_sel), 32'd0);
    chk({tag, "_data"}, 32'(dig_data), 32'd0);
    chk({tag, "_gnt"}, 32'(bus.cpu_gnt), 32'd0);
    chk({tag, "_we"}, 32'(bus.ram_we), 32'd0);
    chk({tag, "_busy"}, 32'(scan_busy), 32'd0);
  endtask

  task automatic idle_cpu();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 6'h0; bus.cpu_din = 4'h0;
  endtask

  initial begin
    int n;
    idle_cpu();
    ifw.cpu_req = 1'b0; ifw.cpu_we = 1'b0; ifw.cpu_addr = 6'h0; ifw.cpu_din = 4'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    // Preload RAM during reset while the core hammers write requests.
    for (int i = 0; i < 64; i++) begin
      bd_we = 1'b1;
      bd_addr = 6'(i);
      if (i >= 'h30 && i <= 'h33) bd_din = 4'(5 + i - 'h30);
      else bd_din = 4'($urandom);
      ref_mem[i] = bd_din;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 6'($urandom); bus.cpu_din = 4'($urandom);
      if (i < 4) chk_reset("por");
      @(negedge clk);
    end
    bd_we = 1'b0;
    idle_cpu();
    model_reset();
    rst_n = 1'b1;

    // Uncontended scan with one core write to digit 1 committing at edge 3.
    repeat (2) step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 6'h31; bus.cpu_din = 4'hA;
    step();
    idle_cpu();
    while (cyc < 19) step();
    #1;
    chk("first_sel", 32'(dig_sel), 32'h1);
    chk("first_data", 32'(dig_data), 32'h5);
    while (cyc < 38) step();
    #1;
    chk("second_sel", 32'(dig_sel), 32'h2);
    chk("second_data", 32'(dig_data), 32'hA);
    while (cyc < 19 * 6) step();

    // Random core traffic.
    repeat (600) begin
      bus.cpu_req = ($urandom_range(0, 9) < 3);
      bus.cpu_we = 1'($urandom);
      bus.cpu_addr = 6'($urandom);
      bus.cpu_din = 4'($urandom);
      step();
    end
    idle_cpu();

    // Core holds the RAM through a whole request window.
    n = 0;
    while ((req_start - cyc) != 2 && n < 100) begin step(); n++; end
    chk("reach_req_window", 32'(n < 100), 32'd1);
    repeat (30) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 6'($urandom);
      step();
    end
    idle_cpu();
    repeat (25) step();

    // Reset while the scanner is requesting.
    n = 0;
    while (cyc < req_start && n < 100) begin step(); n++; end
    chk("reach_req", 32'(n < 100), 32'd1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = BASE; bus.cpu_din = ~ref_mem[BASE];
    rst_n = 1'b0;
    chk_reset("rst_req");
    @(negedge clk);
    chk_reset("rst_req_hold");
    @(negedge clk);
    idle_cpu();
    model_reset();
    rst_n = 1'b1;

    // Reset again in the blanking gap.
    n = 0;
    while (!(show_at > cyc && cyc == show_at - 1) && n < 100) begin step(); n++; end
    chk("reach_blank", 32'(n < 100), 32'd1);
    #1;
    chk("in_blank_sel", 32'(dig_sel), 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = BASE; bus.cpu_din = ~ref_mem[BASE];
    rst_n = 1'b0;
    chk_reset("rst_blank");
    @(negedge clk);
    idle_cpu();
    model_reset();
    rst_n = 1'b1;
    while (cyc < 19) step();
    #1;
    chk("restart_sel", 32'(dig_sel), 32'h1);
    chk("restart_data", 32'(dig_data), 32'(ref_mem[BASE]));
    while (cyc < 80) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
